control_unit: RTL and testbench

- Microcoded-style control decoder for the 8-bit accumulator CPU.
- Takes the current FSM state from the datapath state register, the instruction register contents and the zero flag.
- Produces the next FSM state and every datapath strobe/select.
- Decoding is combinational; the only storage is a sticky halt latch, clocked by clk and cleared by synchronous reset.

---
 rtl/control_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: combinational control decoder for the 8-bit accumulator CPU.
// Decodes the current FSM state, the instruction register and the zero flag
// into the next FSM state and every datapath strobe/select. The only storage
// is a sticky halt latch (halt_q).
//
// Ports:
//   clk          in   1  clock for the halt latch only
//   reset        in   1  synchronous, active-high reset
//   instr        in   8  instruction register: [7:5] opcode, [4] modifier, [3:0] operand
//   state        in   3  current FSM state
//   zf           in   1  zero flag
//   next_state   out  3  state to load on the next clk edge
//   pc_we        out  1  PC write enable
//   pc_sel       out  1  PC source: 0=PC+1, 1=jump target
//   pc_jmp_sel   out  1  jump mode: 0=absolute, 1=PC-relative
//   pc_offset    out  4  jump operand
//   addr_sel     out  1  memory address source: 0=PC, 1=addr_offset
//   addr_offset  out  4  data address
//   mem_sel      out  1  store data source: 0=A, 1=B
//   mem_we       out  1  memory write enable
//   alu_opcode   out  3  ALU operation
//   alu_sel_a    out  1  ALU A input: 0=A, 1=PC
//   alu_sel_b    out  1  ALU B input: 0=B, 1=zero-extended instr[3:0]
//   alu_we       out  1  ALU result register write enable
//   zf_we        out  1  zero flag write enable
//   ir_we        out  1  instruction register write enable
//   a_sel        out  1  A source: 0=ALU result, 1=memory data
//   a_we         out  1  A write enable
//   b_sel        out  1  B source: 0=ALU result, 1=memory data
//   b_we         out  1  B write enable
//   halt         out  1  processor halted
module control_unit (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] instr,
   input  logic [2:0] state,
   input  logic       zf,
   output logic [2:0] next_state,
   output logic       pc_we,
   output logic       pc_sel,
   output logic       pc_jmp_sel,
   output logic [3:0] pc_offset,
   output logic       addr_sel,
   output logic [3:0] addr_offset,
   output logic       mem_sel,
   output logic       mem_we,
   output logic [2:0] alu_opcode,
   output logic       alu_sel_a,
   output logic       alu_sel_b,
   output logic       alu_we,
   output logic       zf_we,
   output logic       ir_we,
   output logic       a_sel,
   output logic       a_we,
   output logic       b_sel,
   output logic       b_we,
   output logic       halt
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned OP_W    = 3;
   localparam int unsigned OPND_W  = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 3'b000,
      S_DECODE    = 3'b001,
      S_EXECUTE   = 3'b010,
      S_MEMORY    = 3'b011,
      S_WRITEBACK = 3'b100,
      S_HALT      = 3'b101
   } state_e;

   localparam logic [OP_W-1:0] OP_LDA  = 3'b000;
   localparam logic [OP_W-1:0] OP_LDB  = 3'b001;
   localparam logic [OP_W-1:0] OP_ST   = 3'b010;
   localparam logic [OP_W-1:0] OP_ALU  = 3'b011;
   localparam logic [OP_W-1:0] OP_ADDI = 3'b100;
   localparam logic [OP_W-1:0] OP_JMP  = 3'b101;
   localparam logic [OP_W-1:0] OP_JZ   = 3'b110;
   localparam logic [OP_W-1:0] OP_HLT  = 3'b111;

   logic [OP_W-1:0]   opcode;
   logic              modifier;
   logic [OPND_W-1:0] operand;
   logic              halt_d;
   logic              halt_q;

   assign opcode   = instr[7:5];
   assign modifier = instr[4];
   assign operand  = instr[3:0];

   // Next-state and strobe decode; every output starts idle
   always_comb begin : decode
      next_state  = S_FETCH;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      pc_jmp_sel  = 1'b0;
      pc_offset   = '0;
      addr_sel    = 1'b0;
      addr_offset = '0;
      mem_sel     = 1'b0;
      mem_we      = 1'b0;
      alu_opcode  = '0;
      alu_sel_a   = 1'b0;
      alu_sel_b   = 1'b0;
      alu_we      = 1'b0;
      zf_we       = 1'b0;
      ir_we       = 1'b0;
      a_sel       = 1'b0;
      a_we        = 1'b0;
      b_sel       = 1'b0;
      b_we        = 1'b0;
      halt        = 1'b0;
      halt_d      = halt_q;

      if (reset) begin
         halt_d = 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               pc_we      = 1'b1;
               ir_we      = 1'b1;
               next_state = S_DECODE;
            end

            S_DECODE: begin
               next_state = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            end

            S_EXECUTE: begin
               case (opcode)
                  OP_LDA, OP_LDB, OP_ST: begin
                     addr_sel    = 1'b1;
                     addr_offset = operand;
                     next_state  = S_MEMORY;
                  end
                  OP_ALU: begin
                     alu_opcode = instr[2:0];
                     alu_we     = 1'b1;
                     zf_we      = 1'b1;
                     next_state = S_WRITEBACK;
                  end
                  OP_ADDI: begin
                     alu_opcode = 3'b000;
                     alu_sel_b  = 1'b1;
                     alu_we     = 1'b1;
                     zf_we      = 1'b1;
                     next_state = S_WRITEBACK;
                  end
                  OP_JMP: begin
                     pc_we      = 1'b1;
                     pc_sel     = 1'b1;
                     pc_jmp_sel = modifier;
                     pc_offset  = operand;
                     next_state = S_FETCH;
                  end
                  OP_JZ: begin
                     // Not-taken branch simply falls through to the next fetch
                     if (zf) begin
                        pc_we      = 1'b1;
                        pc_sel     = 1'b1;
                        pc_jmp_sel = modifier;
                        pc_offset  = operand;
                     end
                     next_state = S_FETCH;
                  end
                  OP_HLT: begin
                     next_state = S_HALT;
                  end
                  default: begin
                     next_state = S_FETCH;
                  end
               endcase
            end

            S_MEMORY: begin
               // Data address stays on the bus for the whole access
               addr_sel    = 1'b1;
               addr_offset = operand;
               case (opcode)
                  OP_LDA: begin
                     a_sel = 1'b1;
                     a_we  = 1'b1;
                  end
                  OP_LDB: begin
                     b_sel = 1'b1;
                     b_we  = 1'b1;
                  end
                  OP_ST: begin
                     mem_sel = modifier;
                     mem_we  = 1'b1;
                  end
                  default: begin
                  end
               endcase
               next_state = S_FETCH;
            end

            S_WRITEBACK: begin
               a_sel      = 1'b0;
               a_we       = 1'b1;
               next_state = S_FETCH;
            end

            S_HALT: begin
               halt       = 1'b1;
               next_state = S_HALT;
            end

            default: begin
               next_state = S_FETCH;
            end
         endcase

         if (state == S_HALT) begin
            halt_d = 1'b1;
         end

         // Once latched, halt freezes all architectural writes until reset
         if (halt_q) begin
            halt       = 1'b1;
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            mem_we     = 1'b0;
            alu_we     = 1'b0;
            zf_we      = 1'b0;
            a_we       = 1'b0;
            b_we       = 1'b0;
            next_state = S_HALT;
         end
      end
   end

   // Sticky halt latch
   always_ff @(posedge clk) begin : halt_reg
      if (reset) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector self-checking bench for control_unit.
// All outputs are packed into one struct so each vector compares every
// output against a hand-built expected value.
module tb_control_unit;

   typedef struct packed {
      logic [2:0] next_state;
      logic       pc_we;
      logic       pc_sel;
      logic       pc_jmp_sel;
      logic [3:0] pc_offset;
      logic       addr_sel;
      logic [3:0] addr_offset;
      logic       mem_sel;
      logic       mem_we;
      logic [2:0] alu_opcode;
      logic       alu_sel_a;
      logic       alu_sel_b;
      logic       alu_we;
      logic       zf_we;
      logic       ir_we;
      logic       a_sel;
      logic       a_we;
      logic       b_sel;
      logic       b_we;
      logic       halt;
   } out_t;

   logic       clk;
   logic       reset;
   logic [7:0] instr;
   logic [2:0] state;
   logic       zf;

   logic [2:0] next_state;
   logic       pc_we, pc_sel, pc_jmp_sel;
   logic [3:0] pc_offset;
   logic       addr_sel;
   logic [3:0] addr_offset;
   logic       mem_sel, mem_we;
   logic [2:0] alu_opcode;
   logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
   logic       a_sel, a_we, b_sel, b_we, halt;

   out_t obs;
   out_t e;
   int   n_cmp;
   int   n_bad;

   control_unit dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .state       (state),
      .zf          (zf),
      .next_state  (next_state),
      .pc_we       (pc_we),
      .pc_sel      (pc_sel),
      .pc_jmp_sel  (pc_jmp_sel),
      .pc_offset   (pc_offset),
      .addr_sel    (addr_sel),
      .addr_offset (addr_offset),
      .mem_sel     (mem_sel),
      .mem_we      (mem_we),
      .alu_opcode  (alu_opcode),
      .alu_sel_a   (alu_sel_a),
      .alu_sel_b   (alu_sel_b),
      .alu_we      (alu_we),
      .zf_we       (zf_we),
      .ir_we       (ir_we),
      .a_sel       (a_sel),
      .a_we        (a_we),
      .b_sel       (b_sel),
      .b_we        (b_we),
      .halt        (halt)
   );

   assign obs = {next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel,
                 addr_offset, mem_sel, mem_we, alu_opcode, alu_sel_a, alu_sel_b,
                 alu_we, zf_we, ir_we, a_sel, a_we, b_sel, b_we, halt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input out_t got, input out_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h (ns=%b halt=%b) expected %h (ns=%b halt=%b)",
                  tag, got, got.next_state, got.halt, exp, exp.next_state, exp.halt);
      end
   endtask

   // Drive inputs and let the combinational decode settle
   task automatic apply(input logic r, input logic [2:0] s, input logic [7:0] i,
                        input logic z);
      reset = r;
      state = s;
      instr = i;
      zf    = z;
      #1;
   endtask

   initial begin
      logic [7:0] fetch_ops [8];
      n_cmp = 0;
      n_bad = 0;
      fetch_ops = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0};
      reset = 1'b1;
      state = 3'b000;
      instr = 8'h00;
      zf    = 1'b0;

      // Reset forces idle regardless of inputs
      @(negedge clk);
      apply(1'b1, 3'b010, 8'hA5, 1'b1);
      e = '0;
      chk("reset_exec", obs, e);
      apply(1'b1, 3'b101, 8'hE0, 1'b0);
      chk("reset_halt_state", obs, e);
      @(negedge clk);
      apply(1'b0, 3'b000, 8'h00, 1'b0);
      e = '0; e.next_state = 3'b001; e.pc_we = 1'b1; e.ir_we = 1'b1;
      chk("post_reset_fetch", obs, e);

      // FETCH ignores instr and zf
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         apply(1'b0, 3'b000, fetch_ops[k % 8], 1'(k / 8));
         chk($sformatf("fetch_%02h_zf%0d", fetch_ops[k % 8], k / 8), obs, e);
      end

      // DECODE
      @(negedge clk);
      apply(1'b0, 3'b001, 8'hE0, 1'b0);
      e = '0; e.next_state = 3'b101;
      chk("decode_hlt", obs, e);
      apply(1'b0, 3'b001, 8'h4F, 1'b1);
      e = '0; e.next_state = 3'b010;
      chk("decode_st", obs, e);

      // EXECUTE ALU then WRITEBACK
      @(negedge clk);
      apply(1'b0, 3'b010, 8'h6B, 1'b0);
      e = '0; e.next_state = 3'b100; e.alu_opcode = 3'b011;
      e.alu_we = 1'b1; e.zf_we = 1'b1;
      chk("exec_alu_6b", obs, e);
      apply(1'b0, 3'b100, 8'h6B, 1'b0);
      e = '0; e.next_state = 3'b000; e.a_we = 1'b1;
      chk("writeback", obs, e);

      // EXECUTE ADDI
      apply(1'b0, 3'b010, 8'h84, 1'b0);
      e = '0; e.next_state = 3'b100; e.alu_sel_b = 1'b1;
      e.alu_we = 1'b1; e.zf_we = 1'b1;
      chk("exec_addi_84", obs, e);

      // EXECUTE JZ taken / not taken, JMP relative
      @(negedge clk);
      apply(1'b0, 3'b010, 8'hC5, 1'b1);
      e = '0; e.pc_we = 1'b1; e.pc_sel = 1'b1; e.pc_offset = 4'b0101;
      chk("exec_jz_taken", obs, e);
      apply(1'b0, 3'b010, 8'hC5, 1'b0);
      e = '0;
      chk("exec_jz_not_taken", obs, e);
      apply(1'b0, 3'b010, 8'hB7, 1'b0);
      e = '0; e.pc_we = 1'b1; e.pc_sel = 1'b1; e.pc_jmp_sel = 1'b1;
      e.pc_offset = 4'h7;
      chk("exec_jmp_rel_b7", obs, e);

      // EXECUTE loads/stores and HLT
      @(negedge clk);
      apply(1'b0, 3'b010, 8'h03, 1'b0);
      e = '0; e.next_state = 3'b011; e.addr_sel = 1'b1; e.addr_offset = 4'h3;
      chk("exec_lda_03", obs, e);
      apply(1'b0, 3'b010, 8'hE0, 1'b1);
      e = '0; e.next_state = 3'b101;
      chk("exec_hlt", obs, e);

      // MEMORY
      @(negedge clk);
      apply(1'b0, 3'b011, 8'h03, 1'b0);
      e = '0; e.addr_sel = 1'b1; e.addr_offset = 4'h3; e.a_sel = 1'b1; e.a_we = 1'b1;
      chk("mem_lda_03", obs, e);
      apply(1'b0, 3'b011, 8'h59, 1'b0);
      e = '0; e.addr_sel = 1'b1; e.addr_offset = 4'h9; e.mem_sel = 1'b1; e.mem_we = 1'b1;
      chk("mem_st_b_59", obs, e);
      apply(1'b0, 3'b011, 8'h2A, 1'b1);
      e = '0; e.addr_sel = 1'b1; e.addr_offset = 4'hA; e.b_sel = 1'b1; e.b_we = 1'b1;
      chk("mem_ldb_2a", obs, e);
      @(negedge clk);
      apply(1'b0, 3'b011, 8'h6B, 1'b0);
      e = '0; e.addr_sel = 1'b1; e.addr_offset = 4'hB;
      chk("mem_other_6b", obs, e);

      // Undefined states
      apply(1'b0, 3'b110, 8'h6B, 1'b1);
      e = '0;
      chk("undef_110", obs, e);
      apply(1'b0, 3'b111, 8'h03, 1'b1);
      chk("undef_111", obs, e);

      // HALT_STATE before the latch is set
      @(negedge clk);
      apply(1'b0, 3'b101, 8'h00, 1'b0);
      e = '0; e.next_state = 3'b101; e.halt = 1'b1;
      chk("halt_state_comb", obs, e);

      // After the edge the latch holds halt and blocks writes
      @(negedge clk);
      apply(1'b0, 3'b000, 8'h00, 1'b0);
      e = '0; e.next_state = 3'b101; e.halt = 1'b1;
      chk("halted_fetch", obs, e);
      apply(1'b0, 3'b010, 8'h6B, 1'b0);
      e = '0; e.next_state = 3'b101; e.halt = 1'b1; e.alu_opcode = 3'b011;
      chk("halted_exec_alu", obs, e);
      apply(1'b0, 3'b011, 8'h59, 1'b0);
      e = '0; e.next_state = 3'b101; e.halt = 1'b1; e.addr_sel = 1'b1;
      e.addr_offset = 4'h9; e.mem_sel = 1'b1;
      chk("halted_mem_st", obs, e);

      // Reset without a clock edge does not clear the latch
      @(negedge clk);
      apply(1'b1, 3'b000, 8'h00, 1'b0);
      e = '0;
      chk("halted_reset_idle", obs, e);
      apply(1'b0, 3'b000, 8'h00, 1'b0);
      e = '0; e.next_state = 3'b101; e.halt = 1'b1;
      chk("halted_reset_no_edge", obs, e);

      // Reset plus clock edge clears it
      apply(1'b1, 3'b000, 8'h00, 1'b0);
      @(negedge clk);
      apply(1'b0, 3'b000, 8'h20, 1'b1);
      e = '0; e.next_state = 3'b001; e.pc_we = 1'b1; e.ir_we = 1'b1;
      chk("unhalted_fetch", obs, e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
